frame_dump_ctrl: RTL and testbench
==================================

Name: frame_dump_ctrl

Overview:
- Sequences readout of the downsampled frame buffer and streams it byte-by-byte to the debug UART.
- Sits between the downsample read port and the uart transmitter, in the 12 MHz read-clock domain.
- A start pulse triggers one complete dump: optional 2-byte sync header, then COLS*ROWS words, 4 bytes each, MSB first.
- Asserts freeze for the whole dump so the buffer writer can hold off updates and the image does not tear.

Parameters:
COLS, 40, words per buffer row (read_x range 0..COLS-1)
ROWS, 30, buffer rows (read_y range 0..ROWS-1)
HOLDOFF, 8191, idle cycles required after tx_busy deasserts before the next byte is written; 1..65535
SEND_HEADER, 1, 1 = emit SYNC0 then SYNC1 before pixel data
SYNC0, 8'hA5, first header byte
SYNC1, 8'h5A, second header byte

Ports:
clk  in  1  system clock (read clock of downsample buffer)
areset_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to begin a dump
abort  in  1  single-cycle request to cancel a dump in progress
rd_x  out  $clog2(COLS)  buffer word column address
rd_y  out  $clog2(ROWS)  buffer row address
rd_data  in  32  buffer read data; valid 1 cycle after rd_x/rd_y change
tx_data  out  8  byte to UART
tx_write  out  1  single-cycle write strobe to UART
tx_busy  in  1  UART transmitting
busy  out  1  dump in progress
freeze  out  1  request to buffer writer to stop updating; equals busy
done  out  1  single-cycle pulse when last byte accepted

Behaviour:
- Reset (async, areset_n low): state IDLE; rd_x=0, rd_y=0, tx_data=0, tx_write=0, busy=0, freeze=0, done=0, holdoff counter=0, byte index=0.
- Holdoff counter: cleared whenever tx_busy=1; otherwise increments, saturating at HOLDOFF (16-bit). A byte is "ready" when counter==HOLDOFF && !tx_busy && !tx_write.
- States:
  - IDLE: on start && !abort -> HDR0 if SEND_HEADER, else ADDR; rd_x=rd_y=0; busy=1 from the next cycle.
  - HDR0: when ready, tx_data=SYNC0, tx_write=1 for one cycle -> HDR1.
  - HDR1: same with SYNC1 -> ADDR.
  - ADDR: address stable; wait one cycle -> LATCH.
  - LATCH: capture rd_data into a 32-bit shift register; byte index=0 -> SEND.
  - SEND: when ready, tx_data = shreg[31:24], tx_write=1, shift left 8, increment byte index.
    - After byte index 3: if rd_x==COLS-1 && rd_y==ROWS-1 -> DONE.
    - Else advance the address -> ADDR. Address advance: rd_x+1, wrapping to 0 with rd_y+1 at COLS-1.
  - DONE: done=1 for one cycle; busy=0, freeze=0 -> IDLE; rd_x=rd_y=0.
- tx_write is never high on two consecutive cycles.
- tx_data is held stable from the strobe until the next strobe.
- Start while busy: ignored.
- Abort: any non-IDLE state -> IDLE on the next edge.
  - tx_write forced 0 that cycle; done not pulsed; addresses reset to 0.
  - A byte already strobed is not recalled.
  - Abort in IDLE, or simultaneous with start in IDLE: no dump starts.
- Total tx_write strobes per dump = 2*SEND_HEADER + 4*COLS*ROWS (4802 at defaults).
- Byte rate is limited only by tx_busy and HOLDOFF; no byte is written within HOLDOFF cycles of tx_busy falling.

Test Plan:
- COLS=2, ROWS=2, HOLDOFF=3; buffer word(x,y) = {y,x,8'hC3,8'h3C}; UART model busy 10 cycles per byte; start -> 18 bytes: A5 5A 00 00 C3 3C 00 01 C3 3C 01 00 C3 3C 01 01 C3 3C; then one done pulse; busy low afterwards.
- Same config: measure gap between tx_busy falling and the next tx_write -> exactly 4 cycles (3 holdoff + 1 register); tx_write never on consecutive cycles.
- SEND_HEADER=0, COLS=3, ROWS=1 -> exactly 12 strobes, first byte is word(0,0)[31:24]; freeze high from start+1 until done.
- Abort after the 7th byte -> no further tx_write, done never pulses, busy=0 next cycle, rd_x=rd_y=0; a subsequent start restarts from the A5 header.
- start pulsed again mid-dump, and start+abort together in IDLE -> byte stream unchanged / no dump; busy stays 0 in the latter case.
- areset_n asserted mid-SEND -> all outputs 0 immediately (asynchronously); after release, IDLE with no spurious tx_write.

Source files
------------

// File: rtl/frame_dump_ctrl.sv
// Frame buffer dump sequencer: reads the downsampled buffer word by word and
// streams it MSB-first to the debug UART, with an optional 2-byte sync header.
module frame_dump_ctrl #(
   parameter int unsigned COLS        = 40,
   parameter int unsigned ROWS        = 30,
   parameter int unsigned HOLDOFF     = 8191,
   parameter bit          SEND_HEADER = 1'b1,
   parameter logic [7:0]  SYNC0       = 8'hA5,
   parameter logic [7:0]  SYNC1       = 8'h5A,
   localparam int unsigned XW = (COLS > 1) ? $clog2(COLS) : 1,
   localparam int unsigned YW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic          clk,
   input  logic          areset_n,
   input  logic          start,
   input  logic          abort,
   output logic [XW-1:0] rd_x,
   output logic [YW-1:0] rd_y,
   input  logic [31:0]   rd_data,
   output logic [7:0]    tx_data,
   output logic          tx_write,
   input  logic          tx_busy,
   output logic          busy,
   output logic          freeze,
   output logic          done
);

   typedef enum logic [2:0] {
      S_IDLE, S_HDR0, S_HDR1, S_ADDR, S_LATCH, S_SEND, S_DONE
   } state_t;

   localparam logic [15:0]   HOLD_MAX = 16'(HOLDOFF);
   localparam logic [XW-1:0] X_LAST   = XW'(COLS - 1);
   localparam logic [YW-1:0] Y_LAST   = YW'(ROWS - 1);

   state_t        state_q;
   logic [15:0]   hold_q, hold_d;
   logic [31:0]   shreg_q;
   logic [1:0]    idx_q;
   logic [XW-1:0] x_q;
   logic [YW-1:0] y_q;
   logic [7:0]    txd_q;
   logic          txw_q;
   logic          busy_q;
   logic          done_q;
   logic          ready;

   // Idle time since the UART last reported busy, saturating at HOLDOFF.
   always_comb begin
      hold_d = hold_q;
      if (tx_busy)
         hold_d = '0;
      else if (hold_q < HOLD_MAX)
         hold_d = hold_q + 16'd1;
   end

   assign ready = (hold_q == HOLD_MAX) && !tx_busy && !txw_q;

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         state_q <= S_IDLE;
         hold_q  <= '0;
         shreg_q <= '0;
         idx_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         txd_q   <= '0;
         txw_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         hold_q <= hold_d;
         txw_q  <= 1'b0;
         done_q <= 1'b0;
         if (abort && state_q != S_IDLE) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (start && !abort) begin
                     state_q <= SEND_HEADER ? S_HDR0 : S_ADDR;
                     x_q     <= '0;
                     y_q     <= '0;
                     busy_q  <= 1'b1;
                  end
               end
               S_HDR0: begin
                  if (ready) begin
                     txd_q   <= SYNC0;
                     txw_q   <= 1'b1;
                     state_q <= S_HDR1;
                  end
               end
               S_HDR1: begin
                  if (ready) begin
                     txd_q   <= SYNC1;
                     txw_q   <= 1'b1;
                     state_q <= S_ADDR;
                  end
               end
               // Buffer read has one cycle of latency after an address change.
               S_ADDR: state_q <= S_LATCH;
               S_LATCH: begin
                  shreg_q <= rd_data;
                  idx_q   <= '0;
                  state_q <= S_SEND;
               end
               S_SEND: begin
                  if (ready) begin
                     txd_q   <= shreg_q[31:24];
                     txw_q   <= 1'b1;
                     shreg_q <= {shreg_q[23:0], 8'h00};
                     idx_q   <= idx_q + 2'd1;
                     if (idx_q == 2'd3) begin
                        if (x_q == X_LAST && y_q == Y_LAST) begin
                           state_q <= S_DONE;
                        end else begin
                           state_q <= S_ADDR;
                           if (x_q == X_LAST) begin
                              x_q <= '0;
                              y_q <= y_q + 1'b1;
                           end else begin
                              x_q <= x_q + 1'b1;
                           end
                        end
                     end
                  end
               end
               S_DONE: begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  x_q     <= '0;
                  y_q     <= '0;
                  state_q <= S_IDLE;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign rd_x     = x_q;
   assign rd_y     = y_q;
   assign tx_data  = txd_q;
   assign tx_write = txw_q;
   assign busy     = busy_q;
   assign freeze   = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_frame_dump_ctrl.sv
// Directed bench for frame_dump_ctrl: two instances (header on 2x2, header off 3x1)
// with a 10-cycle-busy UART model and a one-cycle-latency buffer model each.
module tb_frame_dump_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic areset_n;
   int   total = 0;
   int   bad   = 0;

   // instance A: COLS=2 ROWS=2 HOLDOFF=3 header on
   logic        start_a = 1'b0, abort_a = 1'b0;
   logic [0:0]  rd_x_a, rd_y_a;
   logic [31:0] rd_data_a = '0;
   logic [7:0]  tx_data_a;
   logic        tx_write_a, busy_a, freeze_a, done_a;
   logic        tx_busy_a = 1'b0;

   // instance B: COLS=3 ROWS=1 HOLDOFF=3 header off
   logic        start_b = 1'b0, abort_b = 1'b0;
   logic [1:0]  rd_x_b;
   logic [0:0]  rd_y_b;
   logic [31:0] rd_data_b = '0;
   logic [7:0]  tx_data_b;
   logic        tx_write_b, busy_b, freeze_b, done_b;
   logic        tx_busy_b = 1'b0;

   frame_dump_ctrl #(.COLS(2), .ROWS(2), .HOLDOFF(3), .SEND_HEADER(1'b1)) dut_a (
      .clk(clk), .areset_n(areset_n), .start(start_a), .abort(abort_a),
      .rd_x(rd_x_a), .rd_y(rd_y_a), .rd_data(rd_data_a), .tx_data(tx_data_a),
      .tx_write(tx_write_a), .tx_busy(tx_busy_a), .busy(busy_a),
      .freeze(freeze_a), .done(done_a));

   frame_dump_ctrl #(.COLS(3), .ROWS(1), .HOLDOFF(3), .SEND_HEADER(1'b0)) dut_b (
      .clk(clk), .areset_n(areset_n), .start(start_b), .abort(abort_b),
      .rd_x(rd_x_b), .rd_y(rd_y_b), .rd_data(rd_data_b), .tx_data(tx_data_b),
      .tx_write(tx_write_b), .tx_busy(tx_busy_b), .busy(busy_b),
      .freeze(freeze_b), .done(done_b));

   // buffer models: word(x,y) = {y, x, C3, 3C}, one cycle after the address
   always @(posedge clk) begin
      rd_data_a <= {8'(rd_y_a), 8'(rd_x_a), 8'hC3, 8'h3C};
      rd_data_b <= {8'(rd_y_b), 8'(rd_x_b), 8'hC3, 8'h3C};
   end

   logic [7:0] qa[$];
   logic [7:0] qb[$];
   int gaps_a[$];
   int consec_a = 0, consec_b = 0, done_cnt_a = 0, done_cnt_b = 0;
   int ucnt_a = 0, ucnt_b = 0, gap_a = 0;
   bit prev_w_a = 1'b0, prev_w_b = 1'b0, gap_on_a = 1'b0;

   // byte capture plus UART model: busy for 10 cycles after each strobe
   always @(negedge clk) begin
      if (gap_on_a) gap_a++;
      if (tx_write_a) begin
         qa.push_back(tx_data_a);
         if (prev_w_a) consec_a++;
         if (gap_on_a) begin
            gaps_a.push_back(gap_a);
            gap_on_a = 1'b0;
         end
      end
      prev_w_a = tx_write_a;
      if (done_a) done_cnt_a++;
      if (tx_write_a) begin
         ucnt_a    = 10;
         tx_busy_a = 1'b1;
      end else if (ucnt_a > 0) begin
         ucnt_a--;
         if (ucnt_a == 0) begin
            tx_busy_a = 1'b0;
            gap_on_a  = 1'b1;
            gap_a     = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (tx_write_b) begin
         qb.push_back(tx_data_b);
         if (prev_w_b) consec_b++;
      end
      prev_w_b = tx_write_b;
      if (done_b) done_cnt_b++;
      if (tx_write_b) begin
         ucnt_b    = 10;
         tx_busy_b = 1'b1;
      end else if (ucnt_b > 0) begin
         ucnt_b--;
         if (ucnt_b == 0) tx_busy_b = 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pulse_a(input logic s, input logic a);
      @(posedge clk); #1 start_a = s; abort_a = a;
      @(posedge clk); #1 start_a = 1'b0; abort_a = 1'b0;
   endtask

   task automatic wait_done_a(input int budget, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #1;
         if (done_a) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_bytes_a(input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk); #1;
         if (qa.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic check_stream_a(input string tag);
      chk({tag, "_count"}, qa.size(), 18);
      for (int i = 0; i < 18 && i < qa.size(); i++)
         chk($sformatf("%s_byte%0d", tag, i), qa[i], exp_a[i]);
   endtask

   logic [7:0] exp_a [18] = '{8'hA5, 8'h5A,
                              8'h00, 8'h00, 8'hC3, 8'h3C, 8'h00, 8'h01, 8'hC3, 8'h3C,
                              8'h01, 8'h00, 8'hC3, 8'h3C, 8'h01, 8'h01, 8'hC3, 8'h3C};

   initial begin
      bit ok;
      int lowfrz, dc, n;
      logic [7:0] eb;

      areset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy",     busy_a,     1'b0);
      chk("rst_freeze",   freeze_a,   1'b0);
      chk("rst_tx_write", tx_write_a, 1'b0);
      chk("rst_tx_data",  tx_data_a,  8'h00);
      chk("rst_done",     done_a,     1'b0);
      chk("rst_rd_xy",    {rd_x_a, rd_y_a}, 2'b00);
      areset_n = 1'b1;
      repeat (10) @(posedge clk);

      // full dump with header
      pulse_a(1'b1, 1'b0);
      chk("a_busy_after_start",   busy_a,   1'b1);
      chk("a_freeze_after_start", freeze_a, 1'b1);
      wait_done_a(3000, ok);
      chk("a_done_seen", ok, 1'b1);
      check_stream_a("a_dump1");
      chk("a_gap_count", gaps_a.size(), 17);
      foreach (gaps_a[i]) chk($sformatf("a_gap%0d", i), gaps_a[i], 4);
      @(posedge clk); #1;
      chk("a_done_one_cycle", done_a, 1'b0);
      chk("a_busy_after_done", busy_a, 1'b0);
      chk("a_addr_after_done", {rd_x_a, rd_y_a}, 2'b00);
      repeat (20) @(posedge clk);
      chk("a_done_count", done_cnt_a, 1);
      qa.delete();
      gaps_a.delete();
      gap_on_a = 1'b0;

      // header off, 3x1
      @(posedge clk); #1 start_b = 1'b1;
      @(posedge clk); #1 start_b = 1'b0;
      chk("b_freeze_after_start", freeze_b, 1'b1);
      lowfrz = 0;
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         if (done_b) begin
            ok = 1'b1;
            break;
         end
         if (freeze_b !== 1'b1) lowfrz++;
      end
      chk("b_done_seen", ok, 1'b1);
      chk("b_freeze_held", lowfrz, 0);
      chk("b_count", qb.size(), 12);
      for (int i = 0; i < 12 && i < qb.size(); i++) begin
         case (i % 4)
            0:       eb = 8'h00;
            1:       eb = 8'(i / 4);
            2:       eb = 8'hC3;
            default: eb = 8'h3C;
         endcase
         chk($sformatf("b_byte%0d", i), qb[i], eb);
      end
      repeat (20) @(posedge clk);
      chk("b_done_count", done_cnt_b, 1);

      // abort after the 7th byte
      dc = done_cnt_a;
      pulse_a(1'b1, 1'b0);
      wait_bytes_a(7, ok);
      chk("abort_reach7", ok, 1'b1);
      pulse_a(1'b0, 1'b1);
      chk("abort_busy",     busy_a,     1'b0);
      chk("abort_freeze",   freeze_a,   1'b0);
      chk("abort_addr",     {rd_x_a, rd_y_a}, 2'b00);
      chk("abort_tx_write", tx_write_a, 1'b0);
      repeat (300) @(posedge clk);
      chk("abort_no_more_bytes", qa.size(), 7);
      chk("abort_no_done", done_cnt_a, dc);

      // restart from header, with a stray start mid-dump
      qa.delete();
      pulse_a(1'b1, 1'b0);
      wait_bytes_a(5, ok);
      chk("restart_reach5", ok, 1'b1);
      pulse_a(1'b1, 1'b0);
      wait_done_a(3000, ok);
      chk("restart_done_seen", ok, 1'b1);
      check_stream_a("restart");
      repeat (20) @(posedge clk);
      chk("restart_done_count", done_cnt_a, dc + 1);
      qa.delete();

      // start with abort in IDLE, then abort alone
      pulse_a(1'b1, 1'b1);
      chk("startabort_busy", busy_a, 1'b0);
      pulse_a(1'b0, 1'b1);
      repeat (50) @(posedge clk);
      #1;
      chk("startabort_busy_later", busy_a, 1'b0);
      chk("startabort_no_bytes", qa.size(), 0);

      // asynchronous reset in the middle of word (1,0)
      pulse_a(1'b1, 1'b0);
      wait_bytes_a(8, ok);
      chk("arst_reach8", ok, 1'b1);
      @(posedge clk); #3 areset_n = 1'b0;
      #1;
      chk("arst_busy",     busy_a,     1'b0);
      chk("arst_freeze",   freeze_a,   1'b0);
      chk("arst_tx_data",  tx_data_a,  8'h00);
      chk("arst_tx_write", tx_write_a, 1'b0);
      chk("arst_done",     done_a,     1'b0);
      chk("arst_rd_xy",    {rd_x_a, rd_y_a}, 2'b00);
      repeat (2) @(posedge clk);
      #1 areset_n = 1'b1;
      n = qa.size();
      repeat (200) @(posedge clk);
      #1;
      chk("arst_no_spurious_write", qa.size(), n);
      chk("arst_idle_busy", busy_a, 1'b0);

      chk("a_no_consecutive_writes", consec_a, 0);
      chk("b_no_consecutive_writes", consec_b, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
